// File: rtl/idst7_32_pkg.sv
// Shared definitions for the inverse 32-point DST-7 stream engine.
//   CBase  : the 32 base magnitudes of the DST7P32 matrix.
//   IdxTab : per (k, n) index into CBase for matrix entry T[k][n].
//   SgnTab : per (k, n) sign code for T[k][n] (zero, plus or minus).
//   state_e: engine state.
package idst7_32_pkg;

  localparam int unsigned NPts      = 32;
  localparam int unsigned CntW      = 5;
  // Largest base magnitude is 90, so X*C needs 7 extra bits.
  localparam int unsigned McmGrowth = 7;

  typedef enum logic [0:0] {
    StAccum = 1'b0,
    StDrain = 1'b1
  } state_e;

  localparam logic [McmGrowth-1:0] CBase [NPts] = '{
    7'd4,  7'd9,  7'd13, 7'd17, 7'd21, 7'd26, 7'd30, 7'd34,
    7'd38, 7'd42, 7'd45, 7'd50, 7'd53, 7'd56, 7'd60, 7'd63,
    7'd66, 7'd68, 7'd72, 7'd74, 7'd77, 7'd78, 7'd80, 7'd82,
    7'd84, 7'd85, 7'd86, 7'd88, 7'd88, 7'd89, 7'd90, 7'd90
  };

  localparam logic [1:0] SgnZero = 2'b00;
  localparam logic [1:0] SgnPos  = 2'b01;
  localparam logic [1:0] SgnNeg  = 2'b11;

  typedef logic [NPts-1:0][NPts-1:0][CntW-1:0] idx_tab_t;
  typedef logic [NPts-1:0][NPts-1:0][1:0]      sgn_tab_t;

  // T[k][n] ~ sin(pi * (2k+1)(n+1) / 65); phase taken modulo one full period (130).
  function automatic int phase_of(int k, int n);
    return ((2 * k + 1) * (n + 1)) % 130;
  endfunction

  function automatic logic [CntW-1:0] route_idx(int k, int n);
    int m;
    m = phase_of(k, n);
    if (m > 65) m = 130 - m;  // second half-period: same magnitude, sign handled separately
    if (m > 32) m = 65 - m;   // sin(pi - a) == sin(a)
    return (m == 0) ? '0 : CntW'(m - 1);
  endfunction

  function automatic logic [1:0] route_sgn(int k, int n);
    int m;
    m = phase_of(k, n);
    if (m == 0 || m == 65) return SgnZero;
    return (m > 65) ? SgnNeg : SgnPos;
  endfunction

  function automatic idx_tab_t build_idx_tab();
    idx_tab_t t;
    for (int k = 0; k < 32; k++) begin
      for (int n = 0; n < 32; n++) begin
        t[k][n] = route_idx(k, n);
      end
    end
    return t;
  endfunction

  function automatic sgn_tab_t build_sgn_tab();
    sgn_tab_t t;
    for (int k = 0; k < 32; k++) begin
      for (int n = 0; n < 32; n++) begin
        t[k][n] = route_sgn(k, n);
      end
    end
    return t;
  endfunction

  localparam idx_tab_t IdxTab = build_idx_tab();
  localparam sgn_tab_t SgnTab = build_sgn_tab();

endpackage

// File: rtl/idst7_32_mcm.sv
// Combinational multiple-constant multiplier: prod_o[i] = x_i * CBase[i].
// Built from shifted copies of x_i summed per set bit of each constant.
//   x_i    : signed input, IN_W bits.
//   prod_o : 32 signed products, IN_W+7 bits each.
module idst7_32_mcm
  import idst7_32_pkg::*;
#(
  parameter int unsigned IN_W = 16
) (
  input  logic signed [IN_W-1:0]           x_i,
  output logic signed [IN_W+McmGrowth-1:0] prod_o [NPts]
);

  localparam int unsigned ProdW = IN_W + McmGrowth;

  logic signed [ProdW-1:0] x_ext;

  assign x_ext = ProdW'(x_i);

  always_comb begin
    for (int unsigned i = 0; i < NPts; i++) begin
      prod_o[i] = '0;
      for (int unsigned b = 0; b < McmGrowth; b++) begin
        if (CBase[i][b]) begin
          prod_o[i] = prod_o[i] + (x_ext <<< b);
        end
      end
    end
  end

endmodule

// File: rtl/idst7_32_stream.sv
// Sequential inverse 32-point DST-7 engine. Accepts N_IN coefficients, one per
// handshake, accumulating each into all 32 outputs, then streams 32 rounded and
// clipped samples.
//   clk, rst              : clock, asynchronous active-high reset.
//   in_valid/in_ready     : coefficient handshake, in_data is coefficient k.
//   out_valid/out_ready   : sample handshake, out_data is sample n.
//   out_last              : marks sample n = 31.
module idst7_32_stream
  import idst7_32_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned SHIFT = 7,
  parameter int unsigned N_IN  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last
);

  localparam int unsigned ProdW = IN_W + McmGrowth;
  localparam logic [CntW-1:0] KLast = CntW'(N_IN - 1);
  localparam logic [CntW-1:0] NLast = CntW'(NPts - 1);
  localparam logic signed [ACC_W-1:0] RoundBias = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] OutMax = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] OutMin = ~OutMax;

  state_e                  state_q;
  logic [CntW-1:0]         k_cnt_q, n_cnt_q;
  logic                    in_ready_q, out_valid_q;
  logic                    in_hs, out_hs;
  logic signed [ProdW-1:0] prod    [NPts];
  logic signed [ACC_W-1:0] contrib [NPts];
  logic signed [ACC_W-1:0] acc_q   [NPts];
  logic signed [ACC_W-1:0] acc_d   [NPts];
  logic signed [ACC_W-1:0] acc_sel, rounded, clipped;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign in_hs     = in_valid && in_ready_q;
  assign out_hs    = out_valid_q && out_ready;

  idst7_32_mcm #(
    .IN_W (IN_W)
  ) u_mcm (
    .x_i    (in_data),
    .prod_o (prod)
  );

  // Route the shared products to each output according to T[k_cnt][n].
  always_comb begin
    for (int unsigned n = 0; n < NPts; n++) begin
      contrib[n] = '0;
      case (SgnTab[k_cnt_q][n])
        SgnPos:  contrib[n] = ACC_W'(prod[IdxTab[k_cnt_q][n]]);
        SgnNeg:  contrib[n] = -ACC_W'(prod[IdxTab[k_cnt_q][n]]);
        default: contrib[n] = '0;
      endcase
    end
  end

  always_comb begin
    for (int unsigned n = 0; n < NPts; n++) begin
      acc_d[n] = acc_q[n];
      if (in_hs) begin
        acc_d[n] = acc_q[n] + contrib[n];
      end else if (out_hs && (n_cnt_q == NLast)) begin
        acc_d[n] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < NPts; n++) begin
        acc_q[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NPts; n++) begin
        acc_q[n] <= acc_d[n];
      end
    end
  end

  // Control FSM; handshake flags are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StAccum;
      k_cnt_q     <= '0;
      n_cnt_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (in_hs) begin
            if (k_cnt_q == KLast) begin
              k_cnt_q     <= '0;
              state_q     <= StDrain;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              k_cnt_q <= k_cnt_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (out_hs) begin
            if (n_cnt_q == NLast) begin
              n_cnt_q     <= '0;
              state_q     <= StAccum;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              n_cnt_q <= n_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= StAccum;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    acc_sel = acc_q[n_cnt_q];
    rounded = (acc_sel + RoundBias) >>> SHIFT;
    if (rounded > OutMax) begin
      clipped = OutMax;
    end else if (rounded < OutMin) begin
      clipped = OutMin;
    end else begin
      clipped = rounded;
    end
  end

  // Accumulators are static in DRAIN, so the sample holds under back-pressure.
  assign out_data = out_valid_q ? clipped[OUT_W-1:0] : '0;
  assign out_last = out_valid_q && (n_cnt_q == NLast);

endmodule
